// File: rtl/bus_sequencer.sv
// bus_sequencer: micro-op sequencer that swaps two operands through a
// three-register / RAM datapath (x -> R2, y -> R3, then exchange via RAM[0..1]).
// Each micro-op state is held for DIV clocks; outputs are registered so they
// are stable for the whole state.
// Optional build macro: BUS_SEQUENCER_SINGLE_STEP_EN adds a 'step' input and
// advances one micro-op per rising edge of step instead of every DIV clocks.
module bus_sequencer #(
  parameter int unsigned DIV = 4
) (
  input  logic       CLK100MHZ,
  input  logic       BTNC,
  input  logic       start,
`ifdef BUS_SEQUENCER_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] din,
  output logic       sel_in,
  output logic [1:0] sel_bus,
  output logic       en1_n,
  output logic       en2_n,
  output logic       en3_n,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic       busy,
  output logic       done,
  output logic [3:0] step_idx
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LDX  = 4'd1,
    X2R2 = 4'd2,
    LDY  = 4'd3,
    Y2R3 = 4'd4,
    R2M0 = 4'd5,
    R3M1 = 4'd6,
    M0R3 = 4'd7,
    M1R2 = 4'd8,
    DONE = 4'd9
  } state_t;

  state_t     state, state_n;
  logic [3:0] xl, xl_n;
  logic [3:0] yl, yl_n;
  logic       adv;

  // Next-cycle output values, decoded from the next state so the registered
  // outputs change on the same edge as the state itself.
  logic [3:0] din_d;
  logic       sel_in_d;
  logic [1:0] sel_bus_d;
  logic       en1_d, en2_d, en3_d;
  logic       ram_we_d;
  logic [3:0] ram_addr_d;
  logic       busy_d, done_d;

`ifdef BUS_SEQUENCER_SINGLE_STEP_EN
  logic step_q;

  // Registered sample of step for rising-edge detection.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) step_q <= 1'b0;
    else      step_q <= step;
  end

  assign adv = step & ~step_q;
`else
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt, cnt_n;

  // Dwell counter register.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) cnt <= '0;
    else      cnt <= cnt_n;
  end

  assign adv = (cnt == LAST);
`endif

  // State and operand-latch register.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      state <= IDLE;
      xl    <= '0;
      yl    <= '0;
    end else begin
      state <= state_n;
      xl    <= xl_n;
      yl    <= yl_n;
    end
  end

  // Next-state logic: accept start only when not busy, otherwise step the program.
  always_comb begin
    state_n = state;
    xl_n    = xl;
    yl_n    = yl;
`ifndef BUS_SEQUENCER_SINGLE_STEP_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = LDX;
          xl_n    = x;
          yl_n    = y;
`ifndef BUS_SEQUENCER_SINGLE_STEP_EN
          cnt_n   = '0;
`endif
        end
      end
      default: begin
`ifdef BUS_SEQUENCER_SINGLE_STEP_EN
        if (adv) state_n = state_t'(state + 4'd1);
`else
        if (adv) begin
          state_n = state_t'(state + 4'd1);
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  // Output decode of the next state; unlisted outputs take idle values.
  always_comb begin
    din_d      = '0;
    sel_in_d   = 1'b1;
    sel_bus_d  = 2'd0;
    en1_d      = 1'b1;
    en2_d      = 1'b1;
    en3_d      = 1'b1;
    ram_we_d   = 1'b0;
    ram_addr_d = '0;
    busy_d     = (state_n != IDLE) && (state_n != DONE);
    done_d     = (state_n == DONE);
    case (state_n)
      LDX:  begin din_d = xl_n; sel_in_d = 1'b0; en1_d = 1'b0; end
      X2R2: begin sel_bus_d = 2'd0; en2_d = 1'b0; end
      LDY:  begin din_d = yl_n; sel_in_d = 1'b0; en1_d = 1'b0; end
      Y2R3: begin sel_bus_d = 2'd0; en3_d = 1'b0; end
      R2M0: begin sel_bus_d = 2'd1; ram_addr_d = 4'd0; ram_we_d = 1'b1; end
      R3M1: begin sel_bus_d = 2'd2; ram_addr_d = 4'd1; ram_we_d = 1'b1; end
      M0R3: begin sel_bus_d = 2'd3; ram_addr_d = 4'd0; en3_d = 1'b0; end
      M1R2: begin sel_bus_d = 2'd3; ram_addr_d = 4'd1; en2_d = 1'b0; end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      din      <= '0;
      sel_in   <= 1'b1;
      sel_bus  <= 2'd0;
      en1_n    <= 1'b1;
      en2_n    <= 1'b1;
      en3_n    <= 1'b1;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      din      <= din_d;
      sel_in   <= sel_in_d;
      sel_bus  <= sel_bus_d;
      en1_n    <= en1_d;
      en2_n    <= en2_d;
      en3_n    <= en3_d;
      ram_we   <= ram_we_d;
      ram_addr <= ram_addr_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign step_idx = state;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter DIV, default 4: number of CLK100MHZ cycles that each micro-op state is held; legal range 2..2^24.
REQ-002 CLK100MHZ  in  1  sole clock; all state changes on its rising edge.
REQ-003 BTNC  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  level-sampled request to run the swap program; accepted only in IDLE or DONE.
REQ-005 x, y  in  4 each  operands, captured on start acceptance.
REQ-006 din  out  4  input-port data for the bus (x or y latched copy).
REQ-007 sel_in  out  1  input mux select: 0=din, 1=bus feedback.
REQ-008 sel_bus  out  2  bus source select: 0=R1, 1=R2, 2=R3, 3=RAM.
REQ-009 en1_n, en2_n, en3_n  out  1 each  active-low register load enables for R1, R2, R3.
REQ-010 ram_we  out  1  RAM write enable, active-high.
REQ-011 ram_addr  out  4  RAM address.
REQ-012 busy  out  1  high in any micro-op state.
REQ-013 done  out  1  high in DONE.
REQ-014 step_idx  out  4  current state code (IDLE=0, micro-ops 1..8, DONE=9).

Function
REQ-015 FSM states, in order: IDLE, LDX, X2R2, LDY, Y2R3, R2M0, R3M1, M0R3, M1R2, DONE.
REQ-016 Output decoding, registered and stable for the whole state; unlisted outputs hold their idle values (en*_n=1, ram_we=0, ram_addr=0, sel_in=1, sel_bus=0, din=0):
  LDX: din=x, sel_in=0, en1_n=0 | X2R2: sel_bus=0, en2_n=0 | LDY: din=y, sel_in=0, en1_n=0 | Y2R3: sel_bus=0, en3_n=0
  R2M0: sel_bus=1, ram_addr=0, ram_we=1 | R3M1: sel_bus=2, ram_addr=1, ram_we=1
  M0R3: sel_bus=3, ram_addr=0, en3_n=0 | M1R2: sel_bus=3, ram_addr=1, en2_n=0.
REQ-017 Step counter counts 0..DIV-1 in every micro-op state; the state advances when the counter equals DIV-1, and the counter wraps to 0 at that edge.
REQ-018 start high in IDLE or DONE: the next edge latches x and y, enters LDX, clears the counter and clears done.
REQ-019 start while busy is ignored; x and y changes while busy have no effect.
REQ-020 Latency: done rises exactly 8*DIV cycles after the start-accepting edge; busy is high for exactly 8*DIV cycles.
REQ-021 DONE holds until start (then goes to LDX) or reset; start held continuously reruns the program back-to-back with no IDLE cycle.
REQ-022 At most one of en1_n, en2_n, en3_n is low and ram_we is never high in the same state as any low en*_n.

Reset
REQ-023 BTNC high at an edge forces IDLE, counter 0, latched x and y 0, done 0, busy 0, and all outputs to idle values, including mid-program; it takes priority over start.
REQ-024 After BTNC falls, start is accepted on the first edge at which it is sampled high.

Configuration
REQ-025 Macro BUS_SEQUENCER_SINGLE_STEP_EN defined: adds input step (1 bit); the state advances only on a 0->1 transition of step, detected with a registered sample; DIV and the counter are unused; step edges in IDLE or DONE are ignored.
REQ-026 Macro BUS_SEQUENCER_SINGLE_STEP_EN undefined: no step port, and timing follows REQ-017.

Verification
REQ-027 DIV=4, x=5, y=A, start pulse of 1 cycle -> step_idx goes 1..8, each held for 4 cycles; done=1 at cycle 32; outputs match the REQ-016 table in every state.
REQ-028 With a behavioural top of R1-R3 and RAM driven by the outputs, same run -> final R2=A, R3=5, RAM[0]=5, RAM[1]=A.
REQ-029 start pulsed again in state R2M0 with x=F -> ignored; the program completes with the original 5/A result.
REQ-030 BTNC asserted for 1 cycle in state M0R3 -> the next edge shows step_idx=0, all outputs idle, busy=0, done=0.
REQ-031 start held high for 70 cycles, DIV=4 -> DONE lasts 1 cycle, then LDX is re-entered; two complete runs, with done high at cycles 32 and 65.
REQ-032 SINGLE_STEP_EN defined, 3 step pulses after start -> step_idx=4 and holds with no further pulses; 5 more pulses -> done=1.
